// File: rtl/life_pkg.sv
// Shared types and constants for the life/respawn manager.
// Ports: none (package only).
package life_pkg;

   typedef enum logic [1:0] {
      ALIVE,
      DYING,
      WAIT,
      OVER
   } player_state_t;

   typedef enum logic [1:0] {
      G_ALIVE,
      G_SQUISH,
      G_GONE
   } gomba_state_t;

   // Per-frame y steps during the death hop (-2 up, +3 down)
   localparam logic [9:0] HOP_UP_DY   = 10'h3FE;
   localparam logic [9:0] HOP_DOWN_DY = 10'h003;

   localparam int EXTRA_LIFE_STOMPS = 8;

endpackage

// File: rtl/player_life_fsm.sv
// One player's death / respawn / lives sequencer with death-hop dy.
// Ports: clk, reset, tick (frame strobe), dead, extra_life in;
//        lives, visible, frozen, respawn (pulse), dy, over out.
module player_life_fsm
   import life_pkg::*;
#(
   parameter int LIVES_INIT     = 3,
   parameter int DEATH_FRAMES   = 60,
   parameter int HOP_UP_FRAMES  = 15,
   parameter int RESPAWN_FRAMES = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       dead,
   input  logic       extra_life,
   output logic [3:0] lives,
   output logic       visible,
   output logic       frozen,
   output logic       respawn,
   output logic [9:0] dy,
   output logic       over
);

   localparam logic [7:0] DEATH_LAST   = 8'(DEATH_FRAMES - 1);
   localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
   localparam logic [7:0] HOP_UP       = 8'(HOP_UP_FRAMES);

   player_state_t state;
   logic [7:0]    cnt;
   logic          death;
   logic          gain;
   logic [3:0]    lives_nxt;

   // respawn is high exactly on the first ALIVE cycle, so it doubles
   // as the guard that masks a not-yet-cleared collision flag
   assign death = (state == ALIVE) && dead && !respawn;
   assign gain  = extra_life && (state != OVER);
   assign over  = (state == OVER);

   // A gain and a death on the same edge cancel out
   always_comb begin
      lives_nxt = lives;
      case ({gain, death})
         2'b10:   lives_nxt = (lives == 4'd9) ? lives : lives + 4'd1;
         2'b01:   lives_nxt = lives - 4'd1;
         default: lives_nxt = lives;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ALIVE;
         cnt     <= 8'd0;
         lives   <= 4'(LIVES_INIT);
         visible <= 1'b1;
         frozen  <= 1'b0;
         respawn <= 1'b0;
         dy      <= 10'd0;
      end else begin
         lives   <= lives_nxt;
         respawn <= 1'b0;
         unique case (state)
            ALIVE: begin
               if (death) begin
                  state  <= DYING;
                  cnt    <= 8'd0;
                  frozen <= 1'b1;
                  dy     <= (HOP_UP != 8'd0) ? HOP_UP_DY : HOP_DOWN_DY;
               end
            end
            DYING: begin
               // dy always holds the step for the next tick
               if (tick) begin
                  if (cnt == DEATH_LAST) begin
                     cnt     <= 8'd0;
                     dy      <= 10'd0;
                     visible <= 1'b0;
                     state   <= (lives_nxt == 4'd0) ? OVER : WAIT;
                  end else begin
                     cnt <= cnt + 8'd1;
                     dy  <= (cnt + 8'd1 < HOP_UP) ? HOP_UP_DY : HOP_DOWN_DY;
                  end
               end
            end
            WAIT: begin
               if (tick) begin
                  if (cnt == RESPAWN_LAST) begin
                     state   <= ALIVE;
                     cnt     <= 8'd0;
                     visible <= 1'b1;
                     frozen  <= 1'b0;
                     respawn <= 1'b1;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
            end
            OVER: begin
               cnt <= 8'd0;
            end
            default: begin
               state <= ALIVE;
            end
         endcase
      end
   end

endmodule

// File: rtl/life_manager.sv
// Death, respawn, lives and score manager for mario, luigi and gomba.
// Ports: Clk, Reset (sync, active-high), frame_Clk (async strobe),
//        mario/luigi/gomba_dead in; per-player lives/visible/frozen/
//        respawn/death_dy, gomba visible/squished/respawn, score,
//        collision_clear, game_over out.
// Option: define LIFE_EXTRA_LIFE_EN for a life every 8 stomps.
module life_manager
   import life_pkg::*;
#(
   parameter int LIVES_INIT           = 3,
   parameter int DEATH_FRAMES         = 60,
   parameter int HOP_UP_FRAMES        = 15,
   parameter int RESPAWN_FRAMES       = 30,
   parameter int SQUISH_FRAMES        = 20,
   parameter int GOMBA_RESPAWN_FRAMES = 120
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_Clk,
   input  logic       mario_dead,
   input  logic       luigi_dead,
   input  logic       gomba_dead,
   output logic [3:0] mario_lives,
   output logic [3:0] luigi_lives,
   output logic       mario_visible,
   output logic       luigi_visible,
   output logic       mario_frozen,
   output logic       luigi_frozen,
   output logic       mario_respawn,
   output logic       luigi_respawn,
   output logic [9:0] mario_death_dy,
   output logic [9:0] luigi_death_dy,
   output logic       gomba_visible,
   output logic       gomba_squished,
   output logic       gomba_respawn,
   output logic [7:0] score,
   output logic       collision_clear,
   output logic       game_over
);

   localparam logic [7:0] SQUISH_LAST = 8'(SQUISH_FRAMES - 1);
   localparam logic [7:0] GONE_LAST   = 8'(GOMBA_RESPAWN_FRAMES - 1);

   logic [2:0]   fsync;
   logic         frame_tick;
   gomba_state_t g_state;
   logic [7:0]   g_cnt;
   logic [7:0]   score_inc;
   logic         stomp;
   logic         extra_life;
   logic         mario_over;
   logic         luigi_over;

   // Two-flop synchronizer, edge detect, registered 1-Clk tick
   always_ff @(posedge Clk) begin
      if (Reset) begin
         fsync      <= 3'd0;
         frame_tick <= 1'b0;
      end else begin
         fsync      <= {fsync[1:0], frame_Clk};
         frame_tick <= fsync[1] & ~fsync[2];
      end
   end

   assign score_inc = score + 8'd1;
   // gomba_respawn marks the first G_ALIVE cycle: entry guard
   assign stomp = (g_state == G_ALIVE) && gomba_dead && !gomba_respawn;

`ifdef LIFE_EXTRA_LIFE_EN
   assign extra_life = stomp && (score != 8'hFF) &&
      ((score_inc % 8'(EXTRA_LIFE_STOMPS)) == 8'd0);
`else
   assign extra_life = 1'b0;
`endif

   player_life_fsm #(
      .LIVES_INIT    (LIVES_INIT),
      .DEATH_FRAMES  (DEATH_FRAMES),
      .HOP_UP_FRAMES (HOP_UP_FRAMES),
      .RESPAWN_FRAMES(RESPAWN_FRAMES)
   ) u_mario (
      .clk       (Clk),
      .reset     (Reset),
      .tick      (frame_tick),
      .dead      (mario_dead),
      .extra_life(extra_life),
      .lives     (mario_lives),
      .visible   (mario_visible),
      .frozen    (mario_frozen),
      .respawn   (mario_respawn),
      .dy        (mario_death_dy),
      .over      (mario_over)
   );

   player_life_fsm #(
      .LIVES_INIT    (LIVES_INIT),
      .DEATH_FRAMES  (DEATH_FRAMES),
      .HOP_UP_FRAMES (HOP_UP_FRAMES),
      .RESPAWN_FRAMES(RESPAWN_FRAMES)
   ) u_luigi (
      .clk       (Clk),
      .reset     (Reset),
      .tick      (frame_tick),
      .dead      (luigi_dead),
      .extra_life(extra_life),
      .lives     (luigi_lives),
      .visible   (luigi_visible),
      .frozen    (luigi_frozen),
      .respawn   (luigi_respawn),
      .dy        (luigi_death_dy),
      .over      (luigi_over)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         g_state        <= G_ALIVE;
         g_cnt          <= 8'd0;
         gomba_visible  <= 1'b1;
         gomba_squished <= 1'b0;
         gomba_respawn  <= 1'b0;
         score          <= 8'd0;
      end else begin
         gomba_respawn <= 1'b0;
         unique case (g_state)
            G_ALIVE: begin
               if (stomp) begin
                  g_state        <= G_SQUISH;
                  g_cnt          <= 8'd0;
                  gomba_squished <= 1'b1;
                  if (score != 8'hFF)
                     score <= score_inc;
               end
            end
            G_SQUISH: begin
               if (frame_tick) begin
                  if (g_cnt == SQUISH_LAST) begin
                     g_state        <= G_GONE;
                     g_cnt          <= 8'd0;
                     gomba_squished <= 1'b0;
                     gomba_visible  <= 1'b0;
                  end else begin
                     g_cnt <= g_cnt + 8'd1;
                  end
               end
            end
            G_GONE: begin
               if (frame_tick) begin
                  if (g_cnt == GONE_LAST) begin
                     g_state       <= G_ALIVE;
                     g_cnt         <= 8'd0;
                     gomba_visible <= 1'b1;
                     gomba_respawn <= 1'b1;
                  end else begin
                     g_cnt <= g_cnt + 8'd1;
                  end
               end
            end
            default: begin
               g_state <= G_ALIVE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         game_over <= 1'b0;
      else
         game_over <= mario_over & luigi_over;
   end

   assign collision_clear = mario_respawn | luigi_respawn | gomba_respawn;

endmodule

// File: tb/tb_life_manager.sv
// Directed bench for life_manager: deaths, hop, game over, gomba, reset.
// Ports: none (top-level bench).
module tb_life_manager;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_Clk;
   logic       mario_dead;
   logic       luigi_dead;
   logic       gomba_dead;
   logic [3:0] mario_lives;
   logic [3:0] luigi_lives;
   logic       mario_visible;
   logic       luigi_visible;
   logic       mario_frozen;
   logic       luigi_frozen;
   logic       mario_respawn;
   logic       luigi_respawn;
   logic [9:0] mario_death_dy;
   logic [9:0] luigi_death_dy;
   logic       gomba_visible;
   logic       gomba_squished;
   logic       gomba_respawn;
   logic [7:0] score;
   logic       collision_clear;
   logic       game_over;

   int vectors     = 0;
   int miscompares = 0;
   int m_resp_n    = 0;
   int clear_n     = 0;
   int c0;

   life_manager dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .frame_Clk      (frame_Clk),
      .mario_dead     (mario_dead),
      .luigi_dead     (luigi_dead),
      .gomba_dead     (gomba_dead),
      .mario_lives    (mario_lives),
      .luigi_lives    (luigi_lives),
      .mario_visible  (mario_visible),
      .luigi_visible  (luigi_visible),
      .mario_frozen   (mario_frozen),
      .luigi_frozen   (luigi_frozen),
      .mario_respawn  (mario_respawn),
      .luigi_respawn  (luigi_respawn),
      .mario_death_dy (mario_death_dy),
      .luigi_death_dy (luigi_death_dy),
      .gomba_visible  (gomba_visible),
      .gomba_squished (gomba_squished),
      .gomba_respawn  (gomba_respawn),
      .score          (score),
      .collision_clear(collision_clear),
      .game_over      (game_over)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (mario_respawn)   m_resp_n <= m_resp_n + 1;
      if (collision_clear) clear_n  <= clear_n + 1;
   end

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(int n = 1);
      repeat (n) @(negedge Clk);
   endtask

   // One frame strobe; on return the tick has been consumed
   task automatic frames(int n);
      repeat (n) begin
         frame_Clk = 1'b1;
         step(2);
         frame_Clk = 1'b0;
         step(2);
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step(2);
      Reset = 1'b0;
      step();
   endtask

   task automatic pulse_mario();
      mario_dead = 1'b1;
      step();
      mario_dead = 1'b0;
   endtask

   task automatic pulse_luigi();
      luigi_dead = 1'b1;
      step();
      luigi_dead = 1'b0;
   endtask

   initial begin
      frame_Clk  = 1'b0;
      mario_dead = 1'b0;
      luigi_dead = 1'b0;
      gomba_dead = 1'b0;
      do_reset();

      check("rst_m_lives", mario_lives, 3);
      check("rst_l_lives", luigi_lives, 3);
      check("rst_m_vis", mario_visible, 1);
      check("rst_m_frz", mario_frozen, 0);
      check("rst_m_dy", mario_death_dy, 0);
      check("rst_g_vis", gomba_visible, 1);
      check("rst_g_sq", gomba_squished, 0);
      check("rst_score", score, 0);
      check("rst_go", game_over, 0);
      check("rst_clr", collision_clear, 0);

      // Death, hop profile, wait, respawn
      pulse_mario();
      check("t1_frozen", mario_frozen, 1);
      check("t1_lives", mario_lives, 2);
      check("t2_dy0", mario_death_dy, 10'h3FE);
      for (int k = 1; k <= 60; k++) begin
         frames(1);
         check("t2_dy", mario_death_dy,
               (k == 60) ? 0 : ((k + 1 <= 15) ? 10'h3FE : 10'h003));
         if (k == 5) begin
            pulse_mario();
            step();
            check("t2_ign_lives", mario_lives, 2);
            check("t2_ign_frz", mario_frozen, 1);
         end
      end
      check("t1_wait_vis", mario_visible, 0);
      check("t1_wait_frz", mario_frozen, 1);
      frames(29);
      check("t1_pre_resp", mario_respawn, 0);
      frames(1);
      check("t1_resp", mario_respawn, 1);
      check("t1_clr", collision_clear, 1);
      check("t1_alive_frz", mario_frozen, 0);
      check("t1_alive_vis", mario_visible, 1);
      step();
      check("t1_resp_end", mario_respawn, 0);
      check("t1_clr_end", collision_clear, 0);

      // Mario out of lives
      step();
      pulse_mario();
      frames(90);
      step();
      check("t3_lives1", mario_lives, 1);
      check("t3_resp_n2", m_resp_n, 2);
      pulse_mario();
      check("t3_lives0", mario_lives, 0);
      frames(60);
      check("t3_over_vis", mario_visible, 0);
      check("t3_over_frz", mario_frozen, 1);
      frames(40);
      step();
      check("t3_no_resp", m_resp_n, 2);
      check("t3_still_vis", mario_visible, 0);

      // Luigi out of lives -> game over
      pulse_luigi();
      frames(90);
      step();
      check("t3_l_lives2", luigi_lives, 2);
      check("t3_l_vis", luigi_visible, 1);
      pulse_luigi();
      frames(90);
      step();
      pulse_luigi();
      check("t3_l_lives0", luigi_lives, 0);
      frames(60);
      check("t3_l_over_vis", luigi_visible, 0);
      check("t3_go_early", game_over, 0);
      step();
      check("t3_go", game_over, 1);

      // Gomba stomp held for 100 cycles
      do_reset();
      gomba_dead = 1'b1;
      step(100);
      gomba_dead = 1'b0;
      check("t4_score", score, 1);
      check("t4_sq", gomba_squished, 1);
      check("t4_g_vis", gomba_visible, 1);
      frames(19);
      check("t4_sq19", gomba_squished, 1);
      frames(1);
      check("t4_sq20", gomba_squished, 0);
      check("t4_gone_vis", gomba_visible, 0);
      frames(119);
      check("t4_pre_resp", gomba_respawn, 0);
      check("t4_pre_vis", gomba_visible, 0);
      frames(1);
      check("t4_resp", gomba_respawn, 1);
      check("t4_resp_vis", gomba_visible, 1);
      check("t4_clr", collision_clear, 1);
      check("t4_score_hold", score, 1);
      step();
      check("t4_resp_end", gomba_respawn, 0);

      // Simultaneous mario and gomba deaths
      do_reset();
      c0 = clear_n;
      mario_dead = 1'b1;
      gomba_dead = 1'b1;
      step();
      mario_dead = 1'b0;
      gomba_dead = 1'b0;
      check("t5_score", score, 1);
      check("t5_lives", mario_lives, 2);
      frames(140);
      step();
      check("t5_clr_pulses", clear_n - c0, 2);

      // Reset mid-DYING
      do_reset();
      pulse_mario();
      gomba_dead = 1'b1;
      step();
      gomba_dead = 1'b0;
      frames(10);
      check("t6_dying", mario_frozen, 1);
      Reset = 1'b1;
      step();
      check("t6_lives", mario_lives, 3);
      check("t6_vis", mario_visible, 1);
      check("t6_frz", mario_frozen, 0);
      check("t6_dy", mario_death_dy, 0);
      check("t6_score", score, 0);
      check("t6_sq", gomba_squished, 0);
      Reset = 1'b0;
      step();

      // Eight stomps: extra life only when the option is built in
      for (int s = 1; s <= 8; s++) begin
         gomba_dead = 1'b1;
         step();
         gomba_dead = 1'b0;
         check("t6_stomp", score, s);
         if (s == 7)
            check("t6_lives7", mario_lives, 3);
         if (s < 8) begin
            frames(140);
            step();
         end
      end
`ifdef LIFE_EXTRA_LIFE_EN
      check("t6_extra_m", mario_lives, 4);
      check("t6_extra_l", luigi_lives, 4);
`else
      check("t6_extra_m", mario_lives, 3);
      check("t6_extra_l", luigi_lives, 3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
